alu32_trace_capture: RTL
========================

# alu32_trace_capture

Synthesizable trace recorder for the alu32 datapath. It captures each {a, b, op, result, flags} transaction into an on-chip FIFO and streams every record out as 13 bytes over a valid/ready byte interface. This is the write side of the alu32 test-vector flow: the bench reads stored vectors, and this block produces them from live hardware for host dump and regression.

## Interface
- ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W records, ADDR_W ≥ 1.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low; clock clk.
- cap_valid  in  1  the ALU transaction on the cap_* inputs is valid this cycle.
- cap_ready  out  1  FIFO not full (informational; the source never stalls).
- cap_a, cap_b  in  32  ALU operands.
- cap_op  in  3  ALU opcode.
- cap_result  in  32  ALU result.
- cap_c, cap_n, cap_z, cap_v  in  1  carry, negative, zero and overflow flags.
- out_data  out  8  serialized record byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the byte.
- out_last  out  1  out_data is byte 12, the last byte of the record.
- count  out  ADDR_W+1  FIFO occupancy; excludes the record held in the serializer.
- drop_cnt  out  16  records lost to a full FIFO; saturates at 16'hFFFF.

## Operation
- Record is 104 bits, sent in byte order 0..12:
  - bytes 0-3: cap_a, MSB first.
  - bytes 4-7: cap_b, MSB first.
  - byte 8: {1'b0, cap_op, cap_c, cap_n, cap_z, cap_v}.
  - bytes 9-12: cap_result, MSB first.
- Capture:
  - A record is written when cap_valid && !full.
  - When cap_valid && full, the record is discarded and drop_cnt increments unless it is already at 16'hFFFF.
  - cap_ready = !full. It is derived from the registered occupancy, so a same-cycle pop does not admit a push into a full FIFO.
- FIFO:
  - Circular buffer with ADDR_W-bit read and write pointers; both wrap DEPTH-1 → 0.
  - count = writes − reads.
  - Push and pop in the same cycle leave count unchanged.
  - Pop never occurs on an empty FIFO; push never occurs on a full FIFO.
- Serializer FSM, states IDLE and SEND:
  - IDLE: when count ≠ 0, pop the head into the 104-bit shift register, clear byte index to 0, go to SEND.
  - SEND: out_valid = 1 and out_data = shift register [103:96].
    - On out_valid && out_ready: shift left 8 bits and increment the byte index.
    - out_last = 1 when the byte index is 12.
  - SEND, last-byte handshake: if count ≠ 0, pop the next record in the same cycle and stay in SEND; otherwise go to IDLE.
- Reset: synchronous. A partial record in the serializer and all FIFO contents are discarded.

## Timing
- Reset values: cap_ready=1, out_valid=0, out_data=8'h00, out_last=0, count=0, drop_cnt=0, FSM=IDLE, pointers=0.
- Latency: a record captured at edge E gives count=1 after E. It is popped at E+1, with out_valid=1 and byte 0 presented after E+1.
- All outputs are registered. out_data and out_last hold stable while out_valid && !out_ready.
- Back-to-back records with out_ready=1 stream with no idle cycle between byte 12 and the next byte 0.
- Throughput is one byte per cycle. A sustained capture rate above 1 record per 13 cycles overflows the FIFO.
- Boundary cases:
  - Capture and pop in the same cycle at count=DEPTH: cap_ready=0, so the capture drops and count becomes DEPTH−1.
  - drop_cnt at 16'hFFFF holds its value.
  - Reset asserted mid-record: after that edge, out_valid=0. The next capture starts at byte 0.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs → all outputs at their reset values; no bytes emitted.
- Single record: a=32'h5, b=32'h3, op=3'b010, result=32'h8, flags 0, out_ready=1 → bytes 00 00 00 05 00 00 00 03 20 00 00 00 08; out_last only on the 13th byte; count returns to 0.
- Flags and backpressure: a=32'hFFFFFFFF, b=32'h1, op=3'b010, result=0, c=1, z=1, out_ready toggling 1,0,1,0 → byte 8 = 8'h2A; out_data held during every stall; byte sequence identical to the unstalled case.
- Overflow (ADDR_W=4): out_ready=0, 20 consecutive captures → 1 record in the serializer, count=16, cap_ready=0, drop_cnt=3. Then drain with out_ready=1 → 17 records in capture order.
- Back-to-back: 2 captures, out_ready=1 → 26 consecutive valid bytes with no gap; out_last on bytes 13 and 26.
- Reset mid-record: reset=0 after byte 5 is accepted → out_valid=0 and count=0 next cycle. A new capture then emits from byte 0 with correct data.

Source files
------------

// File: rtl/alu32_trace_capture.sv
// alu32_trace_capture: records each ALU transaction {a, b, op, flags, result}
// into a circular FIFO and streams every 104-bit record out as 13 bytes,
// MSB first, over a valid/ready byte interface.
module alu32_trace_capture #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_valid,
    output logic              cap_ready,
    input  logic [31:0]       cap_a,
    input  logic [31:0]       cap_b,
    input  logic [2:0]        cap_op,
    input  logic [31:0]       cap_result,
    input  logic              cap_c,
    input  logic              cap_n,
    input  logic              cap_z,
    input  logic              cap_v,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       drop_cnt
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAST_IX = 4'd12;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_next;
    logic [103:0]        mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count_next;
    logic [103:0]        shreg;
    logic [103:0]        record;
    logic [3:0]          idx;
    logic                push, pop, nonempty;

    // Saturating increment for the drop counter: sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign record    = {cap_a, cap_b, 1'b0, cap_op, cap_c, cap_n, cap_z, cap_v, cap_result};
    assign push      = cap_valid && cap_ready;
    assign nonempty  = (count != '0);
    assign out_valid = (state == SEND);
    assign out_data  = shreg[103:96];

    // Serializer next-state and pop decision; a pop on the last byte chains records without a gap.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (nonempty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready && idx == LAST_IX) begin
                    if (nonempty) pop = 1'b1;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        count_next = count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FIFO pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cap_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            cap_ready <= (count_next != DEPTH_C);
        end
    end

    // FIFO storage; data only, never reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= record;
    end

    // Count records discarded because the FIFO was full.
    always_ff @(posedge clk) begin
        if (!reset)                       drop_cnt <= '0;
        else if (cap_valid && !cap_ready) drop_cnt <= sat_inc(drop_cnt);
    end

    // Shift register and byte index: load on pop, advance on each accepted byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg    <= '0;
            idx      <= '0;
            out_last <= 1'b0;
        end else if (pop) begin
            shreg    <= mem[rd_ptr];
            idx      <= '0;
            out_last <= 1'b0;
        end else if (state == SEND && out_ready) begin
            shreg    <= {shreg[95:0], 8'h00};
            idx      <= idx + 4'd1;
            out_last <= (idx == LAST_IX - 4'd1);
        end
    end

endmodule
